// File: rtl/rv_imem_pkg.sv
// Shared types and constants for the clocked instruction memory.
// Fault bit positions index rsp_fault; NOP_INSTR is addi x0,x0,0.
package rv_imem_pkg;

    typedef enum logic [1:0] {IM_LOAD, IM_RUN, IM_DRAIN} imem_state_e;

    localparam int unsigned FAULT_MISALIGN = 0;
    localparam int unsigned FAULT_RANGE    = 1;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

endpackage

// File: rtl/imem_array.sv
// Instruction word storage with a per-word valid bit.
// One write port, combinational read, synchronous clear of all valid bits.
module imem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  vbit_q, vbit_d;

    // Storage is deliberately not reset; the valid bits alone gate its use.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        vbit_d = vbit_q;
        if (clear) begin
            vbit_d = '0;
        end else if (we) begin
            vbit_d[waddr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vbit_q <= '0;
        end else begin
            vbit_q <= vbit_d;
        end
    end

    assign rdata  = mem_q[raddr];
    assign rvalid = vbit_q[raddr];

endmodule

// File: rtl/instr_mem_fetch.sv
// Word-addressed instruction memory: boot-load port plus valid/ready fetch port
// with a registered, single-cycle-latency response. Faulted or unloaded fetches return NOP.
module instr_mem_fetch #(
    parameter int unsigned      DATA_W    = 32,
    parameter int unsigned      ADDR_W    = 32,
    parameter int unsigned      DEPTH     = 64,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(rv_imem_pkg::NOP_INSTR)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              prog_last,
    input  logic              reload_req,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_fault,
    output logic              loaded,
    output logic              prog_overflow
);

    import rv_imem_pkg::*;

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    imem_state_e       state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              ovf_q, ovf_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]        rsp_fault_q, rsp_fault_d;

    logic              ptr_full, wr_en, clear_vbits, accept;
    logic              misalign, out_of_range;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    assign ptr_full     = (ptr_q == PTR_W'(DEPTH));
    assign wr_en        = (state_q == IM_LOAD) && prog_valid && !ptr_full;
    assign rd_idx       = req_addr[IDX_W+1:2];
    assign misalign     = |req_addr[1:0];
    assign out_of_range = (req_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH));
    assign req_ready    = (state_q == IM_RUN) && !reload_req && (!rsp_valid_q || rsp_ready);
    assign accept       = req_valid && req_ready;

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear_vbits),
        .we      (wr_en),
        .waddr   (ptr_q[IDX_W-1:0]),
        .wdata   (prog_data),
        .raddr   (rd_idx),
        .rdata   (rd_data),
        .rvalid  (rd_valid)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        ovf_d       = ovf_q;
        clear_vbits = 1'b0;
        unique case (state_q)
            IM_LOAD: begin
                if (prog_valid) begin
                    if (ptr_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                    if (prog_last) begin
                        state_d = IM_RUN;
                    end
                end
            end
            IM_RUN: begin
                if (reload_req) begin
                    state_d = (rsp_valid_q && !rsp_ready) ? IM_DRAIN : IM_LOAD;
                end
            end
            IM_DRAIN: begin
                if (!rsp_valid_q || rsp_ready) begin
                    state_d = IM_LOAD;
                end
            end
            default: state_d = IM_LOAD;
        endcase
        // A fresh load always starts from an empty, zero-pointer memory.
        if ((state_d == IM_LOAD) && (state_q != IM_LOAD)) begin
            ptr_d       = '0;
            clear_vbits = 1'b1;
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_fault_d = rsp_fault_q;
        if (accept) begin
            rsp_valid_d                 = 1'b1;
            rsp_fault_d[FAULT_MISALIGN] = misalign;
            rsp_fault_d[FAULT_RANGE]    = out_of_range;
            rsp_data_d = (misalign || out_of_range || !rd_valid) ? NOP_INSTR : rd_data;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IM_LOAD;
            ptr_q       <= '0;
            ovf_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= NOP_INSTR;
            rsp_fault_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ovf_q       <= ovf_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_fault     = rsp_fault_q;
    assign loaded        = (state_q == IM_RUN);
    assign prog_overflow = ovf_q;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Self-checking bench for instr_mem_fetch: directed scenarios followed by random
// traffic, all compared against a behavioural model of the memory and its handshakes.
module tb_instr_mem_fetch;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 64;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic              clk;
    logic              reset_n;
    logic              prog_valid;
    logic [DATA_W-1:0] prog_data;
    logic              prog_last;
    logic              reload_req;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_fault;
    logic              loaded;
    logic              prog_overflow;

    instr_mem_fetch #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .prog_valid    (prog_valid),
        .prog_data     (prog_data),
        .prog_last     (prog_last),
        .reload_req    (reload_req),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_fault     (rsp_fault),
        .loaded        (loaded),
        .prog_overflow (prog_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Model: mode 0 = loading, 1 = running, 2 = waiting for the stalled response to drain.
    logic [31:0] m_mem [DEPTH];
    bit          m_vld [DEPTH];
    int          m_ptr;
    bit          m_ovf;
    int          m_mode;
    bit          m_rv;
    logic [31:0] m_rd;
    logic [1:0]  m_rf;

    logic [31:0] t2_words [4];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_ptr = 0;
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    endtask

    task automatic model_reset();
        model_clear();
        m_mode = 0;
        m_ovf  = 1'b0;
        m_rv   = 1'b0;
        m_rd   = NOP;
        m_rf   = 2'b00;
    endtask

    // One clock of stimulus: drive at negedge, compare, then advance the model across the edge.
    task automatic cycle(input bit pv, input logic [31:0] pd, input bit pl, input bit rl,
                         input bit rv, input logic [31:0] ra, input bit rr);
        bit          exp_ready;
        bit          rv_old;
        bit          mis;
        bit          rng;
        logic [31:0] wa;
        @(negedge clk);
        prog_valid = pv;
        prog_data  = pd;
        prog_last  = pl;
        reload_req = rl;
        req_valid  = rv;
        req_addr   = ra;
        rsp_ready  = rr;
        #1;
        exp_ready = (m_mode == 1) && !rl && (!m_rv || rr);
        check_eq("req_ready", req_ready, exp_ready);
        check_eq("rsp_valid", rsp_valid, m_rv);
        check_eq("rsp_data", rsp_data, m_rd);
        check_eq("rsp_fault", rsp_fault, m_rf);
        check_eq("loaded", loaded, m_mode == 1);
        check_eq("prog_overflow", prog_overflow, m_ovf);

        rv_old = m_rv;
        if (rv && exp_ready) begin
            wa   = ra >> 2;
            mis  = (ra % 4) != 0;
            rng  = wa >= DEPTH;
            m_rf = {rng, mis};
            if (mis || rng) m_rd = NOP;
            else            m_rd = m_vld[wa] ? m_mem[wa] : NOP;
            m_rv = 1'b1;
        end else if (m_rv && rr) begin
            m_rv = 1'b0;
        end

        case (m_mode)
            0: if (pv) begin
                if (m_ptr < DEPTH) begin
                    m_mem[m_ptr] = pd;
                    m_vld[m_ptr] = 1'b1;
                    m_ptr++;
                end else begin
                    m_ovf = 1'b1;
                end
                if (pl) m_mode = 1;
            end
            1: if (rl) begin
                if (rv_old && !rr) begin
                    m_mode = 2;
                end else begin
                    m_mode = 0;
                    model_clear();
                end
            end
            default: if (!rv_old || rr) begin
                m_mode = 0;
                model_clear();
            end
        endcase
    endtask

    task automatic idle(input bit rr);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, rr);
    endtask

    task automatic fetch(input logic [31:0] ra, input bit rr);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, ra, rr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n    = 1'b0;
        prog_valid = 1'b0;
        prog_last  = 1'b0;
        reload_req = 1'b0;
        req_valid  = 1'b0;
        rsp_ready  = 1'b0;
        #1;
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_req_ready", req_ready, 1'b0);
        check_eq("rst_loaded", loaded, 1'b0);
        check_eq("rst_rsp_data", rsp_data, NOP);
        check_eq("rst_rsp_fault", rsp_fault, 2'b00);
        check_eq("rst_prog_overflow", prog_overflow, 1'b0);
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset_n    = 1'b1;
        prog_valid = 1'b0;
        prog_data  = '0;
        prog_last  = 1'b0;
        reload_req = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        rsp_ready  = 1'b0;
        t2_words[0] = 32'h0020_80B3;
        t2_words[1] = 32'h4020_8133;
        t2_words[2] = 32'h0031_F1B3;
        t2_words[3] = 32'h0021_6233;
        model_reset();

        // T1: reset values
        do_reset();

        // T2: boot-load four words, fetch them back-to-back
        for (int i = 0; i < 4; i++) cycle(1'b1, t2_words[i], i == 3, 1'b0, 1'b0, 32'h0, 1'b1);
        @(posedge clk); #1 check_eq("t2_loaded", loaded, 1'b1);
        for (int i = 0; i < 4; i++) begin
            fetch(32'(4 * i), 1'b1);
            @(posedge clk); #1;
            check_eq("t2_word", rsp_data, t2_words[i]);
            check_eq("t2_fault", rsp_fault, 2'b00);
        end

        // T3: misaligned, out of range, unloaded
        fetch(32'h6, 1'b1);
        @(posedge clk); #1;
        check_eq("t3_mis_fault", rsp_fault, 2'b01);
        check_eq("t3_mis_data", rsp_data, NOP);
        fetch(32'(4 * DEPTH), 1'b1);
        @(posedge clk); #1;
        check_eq("t3_rng_fault", rsp_fault, 2'b10);
        check_eq("t3_rng_data", rsp_data, NOP);
        fetch(32'h10, 1'b1);
        @(posedge clk); #1;
        check_eq("t3_unl_fault", rsp_fault, 2'b00);
        check_eq("t3_unl_data", rsp_data, NOP);

        // T4: backpressure holds the response and blocks new accepts
        fetch(32'h4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            fetch(32'h8, 1'b0);
            @(posedge clk); #1;
            check_eq("t4_hold_data", rsp_data, 32'h4020_8133);
            check_eq("t4_hold_ready", req_ready, 1'b0);
        end
        idle(1'b1);
        @(posedge clk); #1 check_eq("t4_release", rsp_valid, 1'b0);

        // T5: reload while the response is stalled, with a colliding request
        fetch(32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h4, 1'b0);
        @(posedge clk); #1 check_eq("t5_drain_loaded", loaded, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        cycle(1'b1, 32'h0050_0093, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        fetch(32'h4, 1'b1);
        @(posedge clk); #1 check_eq("t5_old_word", rsp_data, NOP);
        fetch(32'h0, 1'b1);
        @(posedge clk); #1 check_eq("t5_new_word", rsp_data, 32'h0050_0093);
        idle(1'b1);

        // T6: one word beyond DEPTH overflows without disturbing memory
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, (i == 0) ? 32'hA5A5_0001 : $urandom, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        end
        cycle(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        @(posedge clk); #1 check_eq("t6_overflow", prog_overflow, 1'b1);
        fetch(32'h0, 1'b1);
        @(posedge clk); #1 check_eq("t6_word0", rsp_data, 32'hA5A5_0001);
        fetch(32'(4 * (DEPTH - 1)), 1'b1);
        idle(1'b1);

        // Random traffic
        do_reset();
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                logic [31:0] ra;
                ra = 32'(4 * $urandom_range(0, DEPTH + 3));
                if ($urandom_range(0, 7) == 0) ra = ra + 32'($urandom_range(1, 3));
                if ($urandom_range(0, 31) == 0) ra = $urandom;
                cycle($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, ra,
                      $urandom_range(0, 3) != 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
